// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address controller for the program counter register.
// Each cycle it picks the PC load value from increment, branch, jump,
// interrupt vector or return-from-interrupt. It holds the PC on stall and
// raises flush on every redirect and for the fetch slot after it.
//
// Optional feature macro: PC_SEQ_IRQ_EN
//   defined   -> interrupt entry/return logic with epc/ie registers
//   undefined -> irq_req_i/reti_i ignored, irq_ack_o/ie_o/epc_o tied to 0
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       synchronous active-low reset
//   pc_i         current PC value (fed back from the PC register)
//   stall_i      hold PC (pipeline back-pressure)
//   br_taken_i   conditional branch resolved taken
//   br_target_i  branch destination
//   jmp_req_i    unconditional jump
//   jmp_target_i jump destination
//   reti_i       return-from-interrupt executed
//   irq_req_i    level interrupt request
//   next_pc_o    PC load value (combinational)
//   flush_o      kill instruction in fetch (combinational)
//   irq_ack_o    one-cycle pulse when an interrupt is taken (combinational)
//   ie_o         interrupt-enable flag (registered)
//   epc_o        saved return address (registered)

module pc_sequencer #(
  parameter int unsigned    AW        = 16,
  parameter logic [AW-1:0]  RESET_VEC = '0,
  parameter logic [AW-1:0]  IRQ_VEC   = AW'(16'h0010)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] pc_i,
  input  logic          stall_i,
  input  logic          br_taken_i,
  input  logic [AW-1:0] br_target_i,
  input  logic          jmp_req_i,
  input  logic [AW-1:0] jmp_target_i,
  input  logic          reti_i,
  input  logic          irq_req_i,
  output logic [AW-1:0] next_pc_o,
  output logic          flush_o,
  output logic          irq_ack_o,
  output logic          ie_o,
  output logic [AW-1:0] epc_o
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_inc;

  // Sequential address, modulo 2^AW.
  assign pc_inc = pc_i + AW'(1);

`ifdef PC_SEQ_IRQ_EN
  logic          ie_q, ie_d;
  logic [AW-1:0] epc_q, epc_d;

  assign ie_o  = ie_q;
  assign epc_o = epc_q;
`else
  logic unused_irq_inputs;

  // Interrupt inputs have no function in this build.
  assign unused_irq_inputs = ^{irq_req_i, reti_i};
  assign ie_o  = 1'b0;
  assign epc_o = '0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  // Interrupt-enable and return-address registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ie_q  <= 1'b1;
      epc_q <= '0;
    end else begin
      ie_q  <= ie_d;
      epc_q <= epc_d;
    end
  end
`endif

  // Next-state, next-address and flush/ack decode.
  always_comb begin
    state_d   = state_q;
    next_pc_o = pc_inc;
    flush_o   = 1'b0;
    irq_ack_o = 1'b0;
`ifdef PC_SEQ_IRQ_EN
    ie_d      = ie_q;
    epc_d     = epc_q;
`endif

    case (state_q)
      ST_BOOT: begin
        next_pc_o = RESET_VEC;
        flush_o   = 1'b1;
        state_d   = ST_RUN;
      end

      ST_RUN: begin
        // Redirects win over stall: the stalled instruction is squashed.
        if (br_taken_i) begin
          next_pc_o = br_target_i;
          flush_o   = 1'b1;
          state_d   = ST_FLUSH;
        end else if (jmp_req_i) begin
          next_pc_o = jmp_target_i;
          flush_o   = 1'b1;
          state_d   = ST_FLUSH;
`ifdef PC_SEQ_IRQ_EN
        end else if (reti_i) begin
          next_pc_o = epc_q;
          flush_o   = 1'b1;
          ie_d      = 1'b1;
          state_d   = ST_FLUSH;
        end else if (irq_req_i && ie_q && !stall_i) begin
          next_pc_o = IRQ_VEC;
          flush_o   = 1'b1;
          irq_ack_o = 1'b1;
          epc_d     = pc_i;
          ie_d      = 1'b0;
          state_d   = ST_FLUSH;
`endif
        end else if (stall_i) begin
          next_pc_o = pc_i;
        end else begin
          next_pc_o = pc_inc;
        end
      end

      ST_FLUSH: begin
        // Requests here come from squashed instructions and are ignored.
        flush_o = 1'b1;
        if (stall_i) begin
          next_pc_o = pc_i;
        end else begin
          next_pc_o = pc_inc;
          state_d   = ST_RUN;
        end
      end

      default: begin
        next_pc_o = RESET_VEC;
        flush_o   = 1'b1;
        state_d   = ST_BOOT;
      end
    endcase

    // Reset holds the fetch at the reset vector with fetch killed.
    if (!rst_ni) begin
      next_pc_o = RESET_VEC;
      flush_o   = 1'b1;
      irq_ack_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer. A bench-side PC
// register closes the next_pc -> pc loop; stimulus queues the expected
// outputs for each cycle and a negedge monitor compares them.

module tb_pc_sequencer;

  localparam int unsigned AW = 16;

`ifdef PC_SEQ_IRQ_EN
  localparam logic IE_RST = 1'b1;
`else
  localparam logic IE_RST = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [15:0] np;
    logic        fl;
    logic        ack;
    bit          chk;
    logic        ie;
    logic [15:0] epc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc_q;
  logic          stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          jmp_req;
  logic [AW-1:0] jmp_target;
  logic          reti;
  logic          irq_req;
  logic [AW-1:0] next_pc;
  logic          flush;
  logic          irq_ack;
  logic          ie;
  logic [AW-1:0] epc;

  exp_t          exp_q[$];
  int            n_vec;
  int            n_bad;
  int            vec_id;
  logic [AW-1:0] np_hold;

  pc_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pc_i         (pc_q),
    .stall_i      (stall),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .jmp_req_i    (jmp_req),
    .jmp_target_i (jmp_target),
    .reti_i       (reti),
    .irq_req_i    (irq_req),
    .next_pc_o    (next_pc),
    .flush_o      (flush),
    .irq_ack_o    (irq_ack),
    .ie_o         (ie),
    .epc_o        (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: model the PC register load (or override it), drive the
  // request inputs and queue the expected outputs for this cycle.
  task automatic cyc(input bit rst, input bit ov, input logic [15:0] ovv,
                     input bit st, input bit br, input logic [15:0] bt,
                     input bit jm, input logic [15:0] jt,
                     input bit rt, input bit iq,
                     input logic [15:0] enp, input bit efl, input bit eack,
                     input bit chk, input logic eie, input logic [15:0] eepc);
    exp_t e;
    @(posedge clk);
    #1;
    pc_q       = ov ? ovv : np_hold;
    rst_n      = ~rst;
    stall      = st;
    br_taken   = br;
    br_target  = bt;
    jmp_req    = jm;
    jmp_target = jt;
    reti       = rt;
    irq_req    = iq;
    vec_id     = vec_id + 1;
    e.id  = vec_id;
    e.np  = enp;
    e.fl  = efl;
    e.ack = eack;
    e.chk = chk;
    e.ie  = eie;
    e.epc = eepc;
    exp_q.push_back(e);
    @(negedge clk);
    np_hold = next_pc;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      bit   bad;
      e   = exp_q.pop_front();
      bad = 1'b0;
      n_vec = n_vec + 1;
      if (next_pc !== e.np) begin
        $display("FAIL vec%0d next_pc: got %h want %h", e.id, next_pc, e.np);
        bad = 1'b1;
      end
      if (flush !== e.fl) begin
        $display("FAIL vec%0d flush: got %b want %b", e.id, flush, e.fl);
        bad = 1'b1;
      end
      if (irq_ack !== e.ack) begin
        $display("FAIL vec%0d irq_ack: got %b want %b", e.id, irq_ack, e.ack);
        bad = 1'b1;
      end
      if (e.chk && (ie !== e.ie)) begin
        $display("FAIL vec%0d ie: got %b want %b", e.id, ie, e.ie);
        bad = 1'b1;
      end
      if (e.chk && (epc !== e.epc)) begin
        $display("FAIL vec%0d epc: got %h want %h", e.id, epc, e.epc);
        bad = 1'b1;
      end
      if (bad) n_bad = n_bad + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_bad = 0; vec_id = 0; np_hold = '0;
    rst_n = 1'b0; pc_q = '0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    jmp_req = 1'b0; jmp_target = '0; reti = 1'b0; irq_req = 1'b0;

    // rst ov ovv st br bt jm jt rt iq | np fl ack chk ie epc
    // Reset held 3 cycles, then BOOT, then sequential 0,1,2.
    cyc(1,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0000,1,0,0,0,16'h0);
    cyc(1,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0000,1,0,1,IE_RST,16'h0);
    cyc(1,0,16'h0,0,1,16'h0,0,16'h0,0,0, 16'h0000,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,1,16'h0abc,1,16'h0def,0,0, 16'h0000,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0001,0,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0002,0,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0003,0,0,1,IE_RST,16'h0);
    // Branch during stall at pc=0040.
    cyc(0,1,16'h0040,1,1,16'h0100,0,16'h0,0,0, 16'h0100,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0101,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0102,0,0,1,IE_RST,16'h0);
    // Branch and jump together: branch wins. FLUSH held by stall, requests ignored.
    cyc(0,0,16'h0,0,1,16'h0200,1,16'h0300,0,0, 16'h0200,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,1,1,16'h0999,0,16'h0,0,0, 16'h0200,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,1,16'h0777,0,0, 16'h0201,1,0,1,IE_RST,16'h0);
    // Plain stall in RUN, then a lone jump.
    cyc(0,0,16'h0,1,0,16'h0,0,16'h0,0,0, 16'h0201,0,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,1,16'h0300,0,0, 16'h0300,1,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0301,1,0,1,IE_RST,16'h0);
    // Wrap-around.
    cyc(0,1,16'hffff,0,0,16'h0,0,16'h0,0,0, 16'h0000,0,0,1,IE_RST,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0001,0,0,1,IE_RST,16'h0);

`ifdef PC_SEQ_IRQ_EN
    // Interrupt at pc=0055 with irq_req held.
    cyc(0,1,16'h0055,0,0,16'h0,0,16'h0,0,1, 16'h0010,1,1,1,1,16'h0000);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0011,1,0,1,0,16'h0055);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0012,0,0,1,0,16'h0055);
    // reti with irq pending: reti wins, interrupt re-taken after FLUSH.
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,1,1, 16'h0055,1,0,1,0,16'h0055);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0056,1,0,1,1,16'h0055);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0010,1,1,1,1,16'h0055);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0011,1,0,1,0,16'h0056);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,1,0, 16'h0056,1,0,1,0,16'h0056);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0057,1,0,1,1,16'h0056);
    // Stall blocks interrupt entry.
    cyc(0,0,16'h0,1,0,16'h0,0,16'h0,0,1, 16'h0057,0,0,1,1,16'h0056);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0058,0,0,1,1,16'h0056);
    // Reset with branch and irq present: no ack, no epc capture.
    cyc(1,0,16'h0,0,1,16'h0123,0,16'h0,0,1, 16'h0000,1,0,1,1,16'h0056);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0000,1,0,1,1,16'h0000);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0001,0,0,1,1,16'h0000);
`else
    // Interrupt inputs have no effect.
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0002,0,0,1,0,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,1,0, 16'h0003,0,0,1,0,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,1,1, 16'h0004,0,0,1,0,16'h0);
    // Reset during FLUSH abandons the redirect.
    cyc(0,0,16'h0,0,1,16'h0040,0,16'h0,0,0, 16'h0040,1,0,1,0,16'h0);
    cyc(1,0,16'h0,0,0,16'h0,0,16'h0,0,0, 16'h0000,1,0,1,0,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0000,1,0,1,0,16'h0);
    cyc(0,0,16'h0,0,0,16'h0,0,16'h0,0,1, 16'h0001,0,0,1,0,16'h0);
`endif

    // Bounded drain of the expectation queue.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      n_bad = n_bad + 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-address controller for the 16-bit program counter register. Each cycle it selects the value loaded into the PC from sequential increment, branch/jump redirect, interrupt vector or return-from-interrupt. It holds the PC on stall and generates fetch-flush bubbles after every redirect. It sits between the execute stage and the PC register: its `next_pc` drives the PC's `load` input, and the PC's `count` feeds back on `pc`.

## Interface
- `AW`, 16, address width; all address ports are `AW` bits.
- `RESET_VEC`, 16'h0000, first fetch address after reset.
- `IRQ_VEC`, 16'h0010, interrupt entry address.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc` in AW: current PC value.
- `stall` in 1: hold PC (pipeline back-pressure).
- `br_taken` in 1: conditional branch resolved taken this cycle.
- `br_target` in AW: branch destination.
- `jmp_req` in 1: unconditional jump this cycle.
- `jmp_target` in AW: jump destination.
- `reti` in 1: return-from-interrupt executed this cycle.
- `irq_req` in 1: level interrupt request.
- `next_pc` out AW: value for the PC `load` input (combinational).
- `flush` out 1: kill the instruction currently in fetch.
- `irq_ack` out 1: one-cycle pulse when an interrupt is taken.
- `ie` out 1: interrupt-enable flag (registered).
- `epc` out AW: saved return address (registered).

## Operation
- States: BOOT, RUN, FLUSH.
- BOOT: `next_pc`=RESET_VEC; `flush`=1; go to RUN unconditionally, ignoring all requests.
- RUN: `next_pc` is chosen by this priority, highest first:
  1. `br_taken` -> `br_target`
  2. `jmp_req` -> `jmp_target`
  3. `reti` -> `epc`, and `ie`<=1
  4. `irq_req`&`ie`&~`stall` -> IRQ_VEC, `epc`<=`pc`, `ie`<=0, `irq_ack`=1
  5. `stall` -> `pc`
  6. otherwise `pc`+1
- Cases 1-4 are redirects: they assert `flush`=1 and move to FLUSH. Cases 5-6 stay in RUN with `flush`=0.
- Redirects override `stall`: the stalled instruction is killed.
- FLUSH: `flush`=1; `next_pc`=`pc` if `stall`, else `pc`+1. Go to RUN only when `stall`=0. `br_taken`, `jmp_req`, `reti` and `irq_req` are ignored, because they come from squashed instructions.
- Arithmetic: `pc`+1 is modulo 2^AW, so 16'hFFFF -> 16'h0000. No carry out.
- `epc` and `ie` change only in the cases listed above.

## Timing
- `next_pc`, `flush` and `irq_ack` are combinational from state and inputs. There is no pipeline latency inside the block. The PC register takes the new value at the next edge, so a redirect reaches `pc` 1 cycle after request.
- A redirect produces exactly 2 flushed fetch slots: the request cycle plus 1 FLUSH cycle. FLUSH extends for as long as `stall` is held.
- Reset (`rst_n`=0 sampled at an edge):
  - state<=BOOT, `epc`<=0, `ie`<=1.
  - While `rst_n`=0: `next_pc`=RESET_VEC, `flush`=1, `irq_ack`=0.
  - Reset mid-redirect or in FLUSH abandons it; no `epc`/`ie` update occurs that cycle.
- `irq_req` held across a taken interrupt is not re-taken, because `ie`=0 until `reti`.
- `reti` and `irq_req` in the same RUN cycle: `reti` wins. The interrupt is taken in RUN after the following FLUSH, since `ie` is then 1.

## Configuration
- `PC_SEQ_IRQ_EN` defined: interrupt logic as above (priority cases 3-4, `epc`, `ie`, `irq_ack`).
- `PC_SEQ_IRQ_EN` not defined:
  - `irq_req` and `reti` are ignored.
  - `irq_ack`=0, `ie`=0 and `epc`=0 constantly.
  - No `epc`/`ie` flops are built; the remaining priority order is unchanged.

## Test plan
- Reset release: `rst_n` low 3 cycles, then high. Require `next_pc`=RESET_VEC and `flush`=1 during reset and the BOOT cycle. The PC then reads 16'h0000, 16'h0001, 16'h0002 on successive cycles.
- Branch during stall: `pc`=16'h0040 with `stall`=1 and `br_taken`=1, `br_target`=16'h0100 in the same cycle. Require `next_pc`=16'h0100 and `flush`=1 for 2 cycles, then `pc` sequence 16'h0100, 16'h0101.
- Simultaneous branch and jump: `br_target`=16'h0200 and `jmp_target`=16'h0300. Require `next_pc`=16'h0200.
- Interrupt round-trip at `pc`=16'h0055 with `irq_req`=1 held:
  - Require one `irq_ack` pulse, `epc`=16'h0055, `ie`=0 and `next_pc`=16'h0010.
  - No second ack while `irq_req` remains high.
  - A later `reti` gives `next_pc`=16'h0055 and `ie`=1.
- Wrap-around: `pc`=16'hFFFF with no requests. Require `next_pc`=16'h0000.
- Macro off (`PC_SEQ_IRQ_EN` undefined): pulse `irq_req` and `reti`. Require `irq_ack`=0 and sequential `next_pc` unaffected.
